// File: rtl/checkbits_mon_pkg.sv
// rtl/checkbits_mon_pkg.sv - shared types for the checkbits sequence monitor
//
// Purpose: FSM state encoding and fail-cause encoding used by
//          checkbits_seq_monitor. No ports (package).

package checkbits_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_RUN,
    ST_PASS,
    ST_FAIL
  } mon_state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE,
    CAUSE_MISMATCH,
    CAUSE_TIMEOUT
  } fail_cause_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter with synchronous clear that sticks at all-ones
//
// Purpose: cycle counter used for total, per-step and timeout latency.
// Ports:
//   i_clk   clock
//   i_rst   asynchronous active-high reset (count -> 0)
//   i_clr   synchronous clear, wins over i_en
//   i_en    count enable
//   o_q     current count, saturates at 2^CNT_W-1

module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;
  logic             w_at_max;

  assign w_at_max = &r_q;
  assign o_q      = r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en && !w_at_max) begin
      r_q <= r_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/checkbits_seq_monitor.sv
// rtl/checkbits_seq_monitor.sv - ordered masked-value sequence monitor for a progress bus
//
// Purpose: once armed, waits for a start code on i_checkbits, then checks an
//          ordered list of masked expected values, measuring per-step and
//          total latency, and reports pass / strict mismatch / timeout.
// Ports:
//   i_clock, i_reset            clock, asynchronous active-high reset
//   i_checkbits                 monitored bus (synchronous to i_clock)
//   i_tbl_we/addr/data/mask     expected-table write port (ignored while busy)
//   i_seq_len                   entries to check, 0..DEPTH
//   i_start_code/i_start_mask   start marker and its compare mask
//   i_timeout_lim               max cycles without progress, 0 = disabled
//   i_strict                    any non-matching masked change fails
//   i_arm                       single-cycle arm / restart pulse
//   o_busy, o_done, o_pass      status levels
//   o_fail_mismatch/o_fail_timeout  fail causes (valid while done)
//   o_cur_idx                   entries matched so far
//   o_step_valid/o_step_lat     one-cycle pulse per match with its step latency
//   o_total_lat                 cycles since start, frozen at done

module checkbits_seq_monitor
  import checkbits_mon_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 32,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [DATA_W-1:0] i_checkbits,
  input  logic              i_tbl_we,
  input  logic [IDX_W-1:0]  i_tbl_addr,
  input  logic [DATA_W-1:0] i_tbl_data,
  input  logic [DATA_W-1:0] i_tbl_mask,
  input  logic [IDX_W:0]    i_seq_len,
  input  logic [DATA_W-1:0] i_start_code,
  input  logic [DATA_W-1:0] i_start_mask,
  input  logic [CNT_W-1:0]  i_timeout_lim,
  input  logic              i_strict,
  input  logic              i_arm,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic              o_fail_mismatch,
  output logic              o_fail_timeout,
  output logic [IDX_W:0]    o_cur_idx,
  output logic              o_step_valid,
  output logic [CNT_W-1:0]  o_step_lat,
  output logic [CNT_W-1:0]  o_total_lat
);

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  mon_state_e        r_state;
  mon_state_e        w_state_nx;
  fail_cause_e       r_cause;

  logic [DATA_W-1:0] r_samp;
  logic [DATA_W-1:0] r_samp_prev;
  logic [DATA_W-1:0] r_exp  [DEPTH];
  logic [DATA_W-1:0] r_mask [DEPTH];
  logic [IDX_W:0]    r_cur_idx;
  logic              r_first;
  logic              r_step_valid;
  logic [CNT_W-1:0]  r_step_lat;

  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_cur_exp;
  logic [DATA_W-1:0] w_cur_mask;
  logic              w_chg;
  logic              w_eq;
  logic              w_start_hit;
  logic [IDX_W:0]    w_idx_inc;
  logic              w_busy;
  logic              w_run;
  logic [CNT_W-1:0]  w_total_q;
  logic [CNT_W-1:0]  w_step_q;
  logic [CNT_W-1:0]  w_to_q;
  logic [CNT_W-1:0]  w_step_inc;
  logic [CNT_W-1:0]  w_to_inc;

  logic              w_clr_cnt;
  logic              w_clr_flags;
  logic              w_go_run;
  logic              w_hit;
  logic              w_fail_mm;
  logic              w_fail_to;

  // Bus sampling: every decision is made on r_samp, one register stage from the pins.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_samp      <= '0;
      r_samp_prev <= '0;
    end else begin
      r_samp      <= i_checkbits;
      r_samp_prev <= r_samp;
    end
  end

  assign w_busy = (r_state == ST_WAIT_START) || (r_state == ST_RUN);
  assign w_run  = (r_state == ST_RUN);

  // Table is frozen while a sequence is being watched.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_exp[i]  <= '0;
        r_mask[i] <= '0;
      end
    end else if (i_tbl_we && !w_busy) begin
      r_exp[i_tbl_addr]  <= i_tbl_data;
      r_mask[i_tbl_addr] <= i_tbl_mask;
    end
  end

  // cur_idx reaches DEPTH only after the last entry, when the table is no
  // longer consulted, so dropping the top bit for the lookup is safe.
  assign w_idx       = r_cur_idx[IDX_W-1:0];
  assign w_cur_exp   = r_exp[w_idx];
  assign w_cur_mask  = r_mask[w_idx];
  assign w_chg       = |((r_samp ^ r_samp_prev) & w_cur_mask);
  assign w_eq        = (r_samp & w_cur_mask) == (w_cur_exp & w_cur_mask);
  assign w_start_hit = (r_samp & i_start_mask) == (i_start_code & i_start_mask);
  assign w_idx_inc   = r_cur_idx + (IDX_W + 1)'(1);
  assign w_step_inc  = f_sat_inc(w_step_q);
  assign w_to_inc    = f_sat_inc(w_to_q);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_clr_cnt   = 1'b0;
    w_clr_flags = 1'b0;
    w_go_run    = 1'b0;
    w_hit       = 1'b0;
    w_fail_mm   = 1'b0;
    w_fail_to   = 1'b0;
    if (i_arm) begin
      // Arm from any state (including busy) restarts the wait for the start code.
      w_state_nx  = ST_WAIT_START;
      w_clr_cnt   = 1'b1;
      w_clr_flags = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nx = ST_IDLE;
        end
        ST_WAIT_START: begin
          if (w_start_hit) begin
            w_clr_cnt   = 1'b1;
            w_clr_flags = 1'b1;
            if (i_seq_len == '0) begin
              w_state_nx = ST_PASS;
            end else begin
              w_state_nx = ST_RUN;
              w_go_run   = 1'b1;
            end
          end
        end
        ST_RUN: begin
          // The first RUN cycle may match without a transition so an entry
          // already present on the bus at start is accepted.
          if (w_eq && (w_chg || r_first)) begin
            w_hit = 1'b1;
            if (w_idx_inc == i_seq_len) begin
              w_state_nx = ST_PASS;
            end
          end else if (i_strict && w_chg) begin
            w_state_nx = ST_FAIL;
            w_fail_mm  = 1'b1;
          end else if ((i_timeout_lim != '0) && (w_to_inc >= i_timeout_lim)) begin
            w_state_nx = ST_FAIL;
            w_fail_to  = 1'b1;
          end
        end
        ST_PASS: begin
          w_state_nx = ST_PASS;
        end
        ST_FAIL: begin
          w_state_nx = ST_FAIL;
        end
        default: begin
          w_state_nx = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_cur_idx    <= '0;
      r_step_lat   <= '0;
      r_step_valid <= 1'b0;
      r_first      <= 1'b0;
      r_cause      <= CAUSE_NONE;
    end else begin
      r_step_valid <= w_hit;
      r_first      <= w_go_run;
      if (w_clr_flags) begin
        r_cur_idx  <= '0;
        r_step_lat <= '0;
        r_cause    <= CAUSE_NONE;
      end else begin
        if (w_hit) begin
          r_cur_idx  <= w_idx_inc;
          r_step_lat <= w_step_inc;
        end
        if (w_fail_mm) begin
          r_cause <= CAUSE_MISMATCH;
        end else if (w_fail_to) begin
          r_cause <= CAUSE_TIMEOUT;
        end
      end
    end
  end

  // total: cycles since start; step and timeout: cycles since start or last match.
  sat_counter #(.CNT_W(CNT_W)) u_total_cnt (
    .i_clk (i_clock),
    .i_rst (i_reset),
    .i_clr (w_clr_cnt),
    .i_en  (w_run),
    .o_q   (w_total_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_step_cnt (
    .i_clk (i_clock),
    .i_rst (i_reset),
    .i_clr (w_clr_cnt || w_hit),
    .i_en  (w_run),
    .o_q   (w_step_q)
  );

  sat_counter #(.CNT_W(CNT_W)) u_timeout_cnt (
    .i_clk (i_clock),
    .i_rst (i_reset),
    .i_clr (w_clr_cnt || w_hit),
    .i_en  (w_run),
    .o_q   (w_to_q)
  );

  assign o_busy          = w_busy;
  assign o_done          = (r_state == ST_PASS) || (r_state == ST_FAIL);
  assign o_pass          = (r_state == ST_PASS);
  assign o_fail_mismatch = (r_state == ST_FAIL) && (r_cause == CAUSE_MISMATCH);
  assign o_fail_timeout  = (r_state == ST_FAIL) && (r_cause == CAUSE_TIMEOUT);
  assign o_cur_idx       = r_cur_idx;
  assign o_step_valid    = r_step_valid;
  assign o_step_lat      = r_step_lat;
  assign o_total_lat     = w_total_q;

endmodule

// File: tb/tb_checkbits_seq_monitor.sv
// tb/tb_checkbits_seq_monitor.sv - directed self-checking bench for checkbits_seq_monitor

module tb_checkbits_seq_monitor;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 32;
  localparam int IDX_W  = 4;

  logic              clk;
  logic              i_reset;
  logic [DATA_W-1:0] i_checkbits;
  logic              i_tbl_we;
  logic [IDX_W-1:0]  i_tbl_addr;
  logic [DATA_W-1:0] i_tbl_data;
  logic [DATA_W-1:0] i_tbl_mask;
  logic [IDX_W:0]    i_seq_len;
  logic [DATA_W-1:0] i_start_code;
  logic [DATA_W-1:0] i_start_mask;
  logic [CNT_W-1:0]  i_timeout_lim;
  logic              i_strict;
  logic              i_arm;
  logic              o_busy;
  logic              o_done;
  logic              o_pass;
  logic              o_fail_mismatch;
  logic              o_fail_timeout;
  logic [IDX_W:0]    o_cur_idx;
  logic              o_step_valid;
  logic [CNT_W-1:0]  o_step_lat;
  logic [CNT_W-1:0]  o_total_lat;

  int checks   = 0;
  int failures = 0;
  logic [CNT_W-1:0] lat_q[$];

  checkbits_seq_monitor #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W), .IDX_W(IDX_W)
  ) dut (
    .i_clock        (clk),
    .i_reset        (i_reset),
    .i_checkbits    (i_checkbits),
    .i_tbl_we       (i_tbl_we),
    .i_tbl_addr     (i_tbl_addr),
    .i_tbl_data     (i_tbl_data),
    .i_tbl_mask     (i_tbl_mask),
    .i_seq_len      (i_seq_len),
    .i_start_code   (i_start_code),
    .i_start_mask   (i_start_mask),
    .i_timeout_lim  (i_timeout_lim),
    .i_strict       (i_strict),
    .i_arm          (i_arm),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_pass         (o_pass),
    .o_fail_mismatch(o_fail_mismatch),
    .o_fail_timeout (o_fail_timeout),
    .o_cur_idx      (o_cur_idx),
    .o_step_valid   (o_step_valid),
    .o_step_lat     (o_step_lat),
    .o_total_lat    (o_total_lat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_step_valid) lat_q.push_back(o_step_lat);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [IDX_W-1:0] a, input logic [DATA_W-1:0] d, input logic [DATA_W-1:0] m);
    i_tbl_we = 1'b1; i_tbl_addr = a; i_tbl_data = d; i_tbl_mask = m;
    step(1);
    i_tbl_we = 1'b0;
  endtask

  task automatic arm_pulse();
    i_arm = 1'b1;
    step(1);
    i_arm = 1'b0;
  endtask

  task automatic load_main();
    wr(0, 16'h0040, 16'hFFFF);
    wr(1, 16'h0893, 16'hFFFF);
    wr(2, 16'h2541, 16'hFFFF);
    wr(3, 16'h2669, 16'hFFFF);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  o_busy, 0);
    check({tag, "_done"},  o_done, 0);
    check({tag, "_pass"},  o_pass, 0);
    check({tag, "_fmm"},   o_fail_mismatch, 0);
    check({tag, "_fto"},   o_fail_timeout, 0);
    check({tag, "_idx"},   o_cur_idx, 0);
    check({tag, "_sv"},    o_step_valid, 0);
    check({tag, "_slat"},  o_step_lat, 0);
    check({tag, "_tlat"},  o_total_lat, 0);
  endtask

  initial begin
    i_reset = 1'b1; i_checkbits = '0; i_tbl_we = 1'b0; i_tbl_addr = '0;
    i_tbl_data = '0; i_tbl_mask = '0; i_seq_len = '0;
    i_start_code = 16'hAB40; i_start_mask = 16'hFFFF;
    i_timeout_lim = '0; i_strict = 1'b0; i_arm = 1'b0;
    step(3);
    check_all_zero("reset");
    i_reset = 1'b0;
    step(1);

    // 1: four entries 10 cycles apart; a table write while busy must be ignored
    lat_q.delete();
    load_main();
    i_seq_len = 5'd4;
    arm_pulse();
    wr(3, 16'h0000, 16'h0000);
    step(1);
    i_checkbits = 16'hAB40; step(10);
    i_checkbits = 16'h0040; step(10);
    i_checkbits = 16'h0893; step(10);
    i_checkbits = 16'h2541; step(10);
    i_checkbits = 16'h2669; step(10);
    check("t1_pass", o_pass, 1);
    check("t1_done", o_done, 1);
    check("t1_busy", o_busy, 0);
    check("t1_idx", o_cur_idx, 4);
    check("t1_npulse", lat_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("t1_slat%0d", i), lat_q[i], 10);
    check("t1_total", o_total_lat, 40);

    // 2a: strict mode, unexpected change fails
    lat_q.delete();
    i_strict = 1'b1;
    i_checkbits = '0;
    arm_pulse();
    check("t2_armclr_pass", o_pass, 0);
    step(1);
    i_checkbits = 16'hAB40; step(10);
    i_checkbits = 16'h0040; step(10);
    i_checkbits = 16'h0055; step(10);
    check("t2_done", o_done, 1);
    check("t2_fmm", o_fail_mismatch, 1);
    check("t2_fto", o_fail_timeout, 0);
    check("t2_pass", o_pass, 0);
    check("t2_idx", o_cur_idx, 1);

    // 2b: same stimulus, non-strict keeps going and a later entry still matches
    lat_q.delete();
    i_strict = 1'b0;
    i_checkbits = '0;
    arm_pulse();
    step(1);
    i_checkbits = 16'hAB40; step(10);
    i_checkbits = 16'h0040; step(10);
    i_checkbits = 16'h0055; step(10);
    check("t2b_done", o_done, 0);
    check("t2b_idx1", o_cur_idx, 1);
    i_checkbits = 16'h0893; step(10);
    check("t2b_idx2", o_cur_idx, 2);
    check("t2b_busy", o_busy, 1);
    check("t2b_slat1", lat_q[1], 20);

    // 3: timeout after exactly 100 RUN cycles (arm while busy restarts)
    lat_q.delete();
    i_timeout_lim = 32'd100;
    i_checkbits = '0;
    arm_pulse();
    step(1);
    i_checkbits = 16'hAB40; step(101);
    check("t3_notyet", o_done, 0);
    step(1);
    check("t3_done", o_done, 1);
    check("t3_fto", o_fail_timeout, 1);
    check("t3_fmm", o_fail_mismatch, 0);
    check("t3_total", o_total_lat, 100);
    check("t3_idx", o_cur_idx, 0);
    check("t3_npulse", lat_q.size(), 0);
    i_timeout_lim = '0;

    // 4: masked entries, last write lands together with arm, upper byte ignored
    lat_q.delete();
    i_strict = 1'b1;
    wr(0, 16'h00A5, 16'h00FF);
    i_tbl_we = 1'b1; i_tbl_addr = 4'd1; i_tbl_data = 16'h005A; i_tbl_mask = 16'h00FF;
    i_seq_len = 5'd2; i_checkbits = '0; i_arm = 1'b1;
    step(1);
    i_tbl_we = 1'b0; i_arm = 1'b0;
    step(1);
    i_checkbits = 16'hAB40; step(10);
    i_checkbits = 16'h12A5; step(5);
    i_checkbits = 16'h34A5; step(5);
    i_checkbits = 16'hFF5A; step(10);
    check("t4_pass", o_pass, 1);
    check("t4_fmm", o_fail_mismatch, 0);
    check("t4_idx", o_cur_idx, 2);
    check("t4_slat0", lat_q[0], 10);
    check("t4_slat1", lat_q[1], 10);
    check("t4_total", o_total_lat, 20);

    // 5: repeated value needs a fresh transition
    lat_q.delete();
    i_strict = 1'b0;
    wr(0, 16'h0003, 16'hFFFF);
    wr(1, 16'h0003, 16'hFFFF);
    i_checkbits = '0;
    arm_pulse();
    step(1);
    i_checkbits = 16'hAB40; step(10);
    i_checkbits = 16'h0003; step(20);
    check("t5_idx_hold", o_cur_idx, 1);
    check("t5_done_hold", o_done, 0);
    check("t5_npulse", lat_q.size(), 1);
    i_checkbits = 16'h0000; step(5);
    i_checkbits = 16'h0003; step(10);
    check("t5_pass", o_pass, 1);
    check("t5_idx", o_cur_idx, 2);
    check("t5_slat1", lat_q[1], 25);
    check("t5_total", o_total_lat, 35);

    // 6: reset mid-RUN clears everything including the table
    lat_q.delete();
    load_main();
    i_seq_len = 5'd4;
    i_checkbits = '0;
    arm_pulse();
    step(1);
    i_checkbits = 16'hAB40; step(10);
    i_checkbits = 16'h0040; step(10);
    i_checkbits = 16'h0893; step(5);
    check("t6_idx_pre", o_cur_idx, 2);
    check("t6_busy_pre", o_busy, 1);
    i_reset = 1'b1;
    step(1);
    check_all_zero("t6_rst");
    i_reset = 1'b0;
    i_seq_len = '0;
    i_checkbits = '0;
    step(1);
    arm_pulse();
    step(1);
    i_checkbits = 16'hAB40; step(5);
    check("t6_len0_pass", o_pass, 1);
    check("t6_len0_total", o_total_lat, 0);
    check("t6_len0_idx", o_cur_idx, 0);
    // cleared entry 0 has mask 0, so it matches on the first RUN cycle
    i_seq_len = 5'd1;
    arm_pulse();
    step(5);
    check("t6_len1_pass", o_pass, 1);
    check("t6_len1_idx", o_cur_idx, 1);
    check("t6_len1_slat", o_step_lat, 1);
    check("t6_len1_total", o_total_lat, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
